// File: rtl/imem_loader.sv
// imem_loader -- writer side of the instruction memory.
//
// Receives a program image as a byte stream over a valid/ready handshake.
// Bytes arrive most-significant first; every four bytes are packed into one
// 32-bit word and written to the instruction SRAM, starting at BASE_ADDR
// and moving upward. While the load is in progress start_up stays high so
// that fetch holds the PC at the start address. start_up drops one cycle
// after the done pulse, and only if the load succeeded.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   load_go     1-cycle pulse: sample word_count and begin a load (IDLE only)
//   word_count  number of 32-bit words in the image
//   byte_valid  byte_data is valid
//   byte_data   stream byte, most-significant byte of each word first
//   byte_ready  loader accepts a byte this cycle (valid & ready = transfer)
//   mem_cs      SRAM chip select (high only while writing)
//   mem_we      SRAM write enable (high only while writing)
//   mem_addr    SRAM byte address, word aligned
//   mem_din     SRAM write data
//   start_up    1 = fetch holds PC at the start address
//   busy        load in progress
//   done        1-cycle pulse at the end of a load, good or bad
//   err         last load failed; sticky until the next accepted load_go
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN -- after the last word, one extra byte is taken
//   that must equal the XOR of all image bytes; a mismatch sets err.

module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0020,
    parameter int          MAX_WORDS = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_go,
    input  logic [CNT_W-1:0] word_count,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_cs,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_din,
    output logic             start_up,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    // State after the final word (or directly after load_go for an empty image).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_LAST = S_CSUM;
`else
    localparam state_t S_AFTER_LAST = S_FIN;
`endif

    state_t           state_q, state_d;
    logic             start_up_q, start_up_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_up_q <= 1'b1;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            mem_addr_q <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            start_up_q <= start_up_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            mem_addr_q <= mem_addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        start_up_d = start_up_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        mem_addr_d = mem_addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        byte_ready = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_go) begin
                    start_up_d = 1'b1;
                    err_d      = 1'b0;
                    cnt_d      = word_count;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    mem_addr_d = BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    // Oversized images are rejected before any byte is consumed.
                    if (word_count > CNT_W'(MAX_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (word_count == '0) begin
                        state_d = S_AFTER_LAST;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end

            S_RECV: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) begin
                    word_d     = {word_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;   // wraps to 0 after the 4th byte
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ byte_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                busy       = 1'b1;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                // mem_addr_q tracks BASE_ADDR + 4*word_idx incrementally.
                mem_addr_d = mem_addr_q + 32'd4;
                word_idx_d = word_idx_q + 1'b1;
                if (word_idx_d == cnt_q) begin
                    state_d = S_AFTER_LAST;
                end else begin
                    state_d = S_RECV;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (byte_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_FIN;
                end
            end
`endif

            S_FIN: begin
                done       = 1'b1;
                // A failed load keeps fetch parked at the start address.
                start_up_d = err_q;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr = mem_addr_q;
    assign mem_din  = word_q;
    assign start_up = start_up_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. Inputs are driven and outputs sampled
// on the falling clock edge; SRAM writes are logged by a small monitor.

module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0040_0020;

    logic        clk;
    logic        rst_n;
    logic        load_go;
    logic [15:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        start_up;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    int          wr_cnt     = 0;
    int          rdy_cycles = 0;
    int          cs_bad     = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_go    (load_go),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .start_up   (start_up),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log: one line per SRAM write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_din;
            end
            wr_cnt++;
            $display("write addr=%h data=%h", mem_addr, mem_din);
        end
        if (mem_cs !== mem_we) cs_bad++;
        if (byte_ready === 1'b1) rdy_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [15:0] cnt);
        word_count = cnt;
        load_go    = 1'b1;
        @(negedge clk);
        load_go    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("byte_accept_timeout", 32'(n < 50), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    int          wr0;
    int          rdy0;
    logic [31:0] w3;

    initial begin
        rst_n      = 1'b0;
        load_go    = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        w3         = 32'hA5C3_0F96;

        // 1. Reset values
        @(negedge clk);
        chk("rst_start_up",   32'(start_up),   32'd1);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_mem_addr",   mem_addr,        BASE);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_err",        32'(err),        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2. Two-word image; a load_go during the load must be ignored
        wr0 = wr_cnt;
        go(16'd2);
        chk("t2_busy", 32'(busy), 32'd1);
        word_count = 16'd0;
        load_go    = 1'b1;
        @(negedge clk);
        load_go    = 1'b0;
        send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hAE);
`endif
        wait_done(10);
        chk("t2_done_busy",     32'(busy),     32'd0);
        chk("t2_done_start_up", 32'(start_up), 32'd1);
        chk("t2_err",           32'(err),      32'd0);
        @(negedge clk);
        chk("t2_start_up_fall", 32'(start_up), 32'd0);
        chk("t2_done_pulse",    32'(done),     32'd0);
        chk("t2_writes",        32'(wr_cnt - wr0), 32'd2);
        chk("t2_addr0", wr_addr[wr0],     32'h0040_0020);
        chk("t2_data0", wr_data[wr0],     32'h8C01_0004);
        chk("t2_addr1", wr_addr[wr0 + 1], 32'h0040_0024);
        chk("t2_data1", wr_data[wr0 + 1], 32'h2002_0005);

        // 3. One word, byte_valid toggling: 8 RECV cycles, write 1 cycle later
        wr0  = wr_cnt;
        rdy0 = rdy_cycles;
        go(16'd1);
        for (int i = 0; i < 8; i++) begin
            byte_valid = i[0];
            byte_data  = w3[31 - 8 * (i / 2) -: 8];
            @(negedge clk);
        end
        byte_valid = 1'b0;
        chk("t3_we_latency", 32'(mem_we), 32'd1);
        chk("t3_din",        mem_din,     w3);
        chk("t3_addr",       mem_addr,    BASE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hFF);
`endif
        wait_done(10);
        @(negedge clk);
        chk("t3_start_up", 32'(start_up), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t3_recv_cycles", 32'(rdy_cycles - rdy0), 32'd9);
`else
        chk("t3_recv_cycles", 32'(rdy_cycles - rdy0), 32'd8);
`endif
        chk("t3_writes", 32'(wr_cnt - wr0), 32'd1);

        // 4a. Empty image
        wr0 = wr_cnt;
        go(16'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_done(2);
        chk("t4_zero_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("t4_zero_start_up", 32'(start_up), 32'd0);
        chk("t4_zero_writes",   32'(wr_cnt - wr0), 32'd0);

        // 4b. Oversized image: rejected without consuming bytes
        rdy0 = rdy_cycles;
        go(16'd1025);
        wait_done(2);
        chk("t4_big_err_at_done", 32'(err), 32'd1);
        @(negedge clk);
        chk("t4_big_start_up", 32'(start_up), 32'd1);
        chk("t4_big_err_sticky", 32'(err), 32'd1);
        chk("t4_big_no_bytes", 32'(rdy_cycles - rdy0), 32'd0);
        chk("t4_big_writes",   32'(wr_cnt - wr0), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6. Checksum good then bad
        go(16'd1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h08);
        wait_done(5);
        chk("t6_good_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("t6_good_start_up", 32'(start_up), 32'd0);
        go(16'd1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'hFF);
        wait_done(5);
        chk("t6_bad_err", 32'(err), 32'd1);
        @(negedge clk);
        chk("t6_bad_start_up", 32'(start_up), 32'd1);
        chk("t6_last_word", wr_data[wr_cnt - 1], 32'h1234_5678);
`endif

        // 5. Reset after two bytes of word 0
        wr0 = wr_cnt;
        go(16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("t5_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_start_up",   32'(start_up),   32'd1);
        chk("t5_byte_ready", 32'(byte_ready), 32'd0);
        chk("t5_busy",       32'(busy),       32'd0);
        chk("t5_err",        32'(err),        32'd0);
        chk("t5_mem_din",    mem_din,         32'd0);
        chk("t5_mem_addr",   mem_addr,        BASE);
        chk("t5_mem_we",     32'(mem_we),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("t5_idle_ready", 32'(byte_ready), 32'd0);

        chk("cs_we_consistent", 32'(cs_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
